// File: rtl/dmem_lsu_pkg.sv
// ============================================================================
// Module  : package_project_typedefs
// Brief   : Shared types and helpers for the dmem_lsu data memory / LSU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package package_project_typedefs;

    localparam int DMEM_LANES  = 4;
    localparam int DMEM_LANE_W = 8;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LH  = 3'd1,
        MEM_LW  = 3'd2,
        MEM_LBU = 3'd3,
        MEM_LHU = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } DataMemOp;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_RESP  = 2'd2
    } DmemLsuState;

    function automatic logic [2:0] op_size(input DataMemOp op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            default:                 return 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input DataMemOp op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Lanes touched by an access, spanning two words: [3:0] word w, [7:4] word w+1.
    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] m;
        m = (size == 3'd1) ? 8'h01 : (size == 3'd2) ? 8'h03 : 8'h0F;
        return m << off;
    endfunction

    // Rotating left by the offset puts store byte i on lane (off+i) mod 4 for both beats.
    function automatic logic [31:0] lane_rotl(input logic [31:0] d, input logic [1:0] off);
        logic [5:0] sh;
        sh = {1'b0, off, 3'b000};
        return (d << sh) | (d >> (6'd32 - sh));
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lsu_lane_ram.sv
// ============================================================================
// Module  : dmem_lane_ram
// Brief   : Single-port 8-bit lane RAM, synchronous read with write enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_ram #(
    parameter int DATA_MEM_DEPTH = 512
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [$clog2(DATA_MEM_DEPTH)-1:0] addr,
    input  logic [7:0]                        wdata,
    output logic [7:0]                        rdata
);

    logic [7:0] mem [DATA_MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
// Module  : dmem_lsu
// Brief   : Byte-lane data memory with load/store unit over valid/ready.
//           DMEM_MISALIGN_SPLIT_EN: split word-crossing accesses into two
//           beats; otherwise reject them with misalign_err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lsu
    import package_project_typedefs::*;
#(
    parameter int DATA_MEM_DEPTH = 512,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  DataMemOp          req_op,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wr_data,
    output logic              rsp_valid,
    output logic [31:0]       rd_data,
    output logic              misalign_err
);

    localparam int IDX_W = $clog2(DATA_MEM_DEPTH);

    DmemLsuState      r_state, w_next_state;
    DataMemOp         r_op;
    logic [1:0]       r_off;
    logic             r_cross;

    logic             w_accept;
    logic             w_in_cross;
    logic [7:0]       w_in_mask;
    logic [IDX_W-1:0] w_ram_addr;
    logic [3:0]       w_lane_we;
    logic [31:0]      w_wdata_rot;
    logic [31:0]      w_ram_rd;
    logic [31:0]      w_lo_word;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load;
    logic             w_unused_addr;

    assign w_unused_addr = ^addr_in[ADDR_W-1:IDX_W+2];

    assign w_accept   = req_valid & req_ready;
    assign w_in_cross = ({1'b0, addr_in[1:0]} + op_size(req_op)) > 3'd4;
    assign w_in_mask  = byte_mask(op_size(req_op), addr_in[1:0]);

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [IDX_W-1:0] r_word;
    logic [31:0]      r_wdata;
    logic [31:0]      r_beat0;
    logic [7:0]       w_reg_mask;

    assign w_reg_mask = byte_mask(op_size(r_op), r_off);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                w_next_state = ST_RESP;
            end
`endif
            ST_RESP: begin
                req_ready    = 1'b1;
                rsp_valid    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_accept) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            w_next_state = w_in_cross ? ST_BEAT1 : ST_RESP;
`else
            w_next_state = ST_RESP;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= MEM_LB;
            r_off   <= 2'd0;
            r_cross <= 1'b0;
        end else if (w_accept) begin
            r_op    <= req_op;
            r_off   <= addr_in[1:0];
            r_cross <= w_in_cross;
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_wdata <= '0;
            r_beat0 <= '0;
        end else begin
            if (w_accept) begin
                r_word  <= addr_in[2 +: IDX_W];
                r_wdata <= wr_data;
            end
            if (r_state == ST_BEAT1) begin
                r_beat0 <= w_ram_rd;
            end
        end
    end
`endif

    // Beat 0 is issued straight from the request inputs so the RAM read lands at acceptance.
    always_comb begin
        w_ram_addr  = addr_in[2 +: IDX_W];
        w_wdata_rot = lane_rotl(wr_data, addr_in[1:0]);
        w_lane_we   = 4'b0000;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (r_state == ST_BEAT1) begin
            w_ram_addr  = r_word + 1'b1;
            w_wdata_rot = lane_rotl(r_wdata, r_off);
            w_lane_we   = op_is_store(r_op) ? w_reg_mask[7:4] : 4'b0000;
        end else if (w_accept && op_is_store(req_op)) begin
            w_lane_we = w_in_mask[3:0];
        end
`else
        if (w_accept && op_is_store(req_op) && !w_in_cross) begin
            w_lane_we = w_in_mask[3:0];
        end
`endif
        if (!rst_n) begin
            w_lane_we = 4'b0000;
        end
    end

    dmem_lane_ram #(.DATA_MEM_DEPTH(DATA_MEM_DEPTH)) lane_ram_0 (
        .clk(clk), .we(w_lane_we[0]), .addr(w_ram_addr),
        .wdata(w_wdata_rot[7:0]), .rdata(w_ram_rd[7:0])
    );
    dmem_lane_ram #(.DATA_MEM_DEPTH(DATA_MEM_DEPTH)) lane_ram_1 (
        .clk(clk), .we(w_lane_we[1]), .addr(w_ram_addr),
        .wdata(w_wdata_rot[15:8]), .rdata(w_ram_rd[15:8])
    );
    dmem_lane_ram #(.DATA_MEM_DEPTH(DATA_MEM_DEPTH)) lane_ram_2 (
        .clk(clk), .we(w_lane_we[2]), .addr(w_ram_addr),
        .wdata(w_wdata_rot[23:16]), .rdata(w_ram_rd[23:16])
    );
    dmem_lane_ram #(.DATA_MEM_DEPTH(DATA_MEM_DEPTH)) lane_ram_3 (
        .clk(clk), .we(w_lane_we[3]), .addr(w_ram_addr),
        .wdata(w_wdata_rot[31:24]), .rdata(w_ram_rd[31:24])
    );

    // Two-word window {word w+1, word w} shifted by the offset yields bytes in address order.
`ifdef DMEM_MISALIGN_SPLIT_EN
    assign w_lo_word = r_cross ? r_beat0 : w_ram_rd;
`else
    assign w_lo_word = w_ram_rd;
`endif
    assign w_shifted = 32'({w_ram_rd, w_lo_word} >> {r_off, 3'b000});

    always_comb begin
        case (r_op)
            MEM_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_LH:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_LW:  w_load = w_shifted;
            MEM_LBU: w_load = {24'h0, w_shifted[7:0]};
            MEM_LHU: w_load = {16'h0, w_shifted[15:0]};
            default: w_load = 32'h0;
        endcase
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign rd_data      = rsp_valid ? w_load : 32'h0;
    assign misalign_err = 1'b0;
`else
    assign rd_data      = (rsp_valid && !r_cross) ? w_load : 32'h0;
    assign misalign_err = rsp_valid & r_cross;
`endif

endmodule

`default_nettype wire
